// File: rtl/code_nco_ctrl_if.sv
// Control-side bundle for the code NCO sequencer: frequency requesters, slew
// requests, the NCO enable path and status strobes.
interface code_nco_ctrl_if;
  logic        hc_enable_in;
  logic        dump_enable;
  logic        sw_freq_valid;
  logic [27:0] sw_freq_data;
  logic        sw_freq_ready;
  logic        loop_freq_valid;
  logic [27:0] loop_freq_data;
  logic        loop_freq_ready;
  logic        slew_valid;
  logic [10:0] slew_count;
  logic        slew_ready;
  logic [27:0] f_control;
  logic        hc_enable_out;
  logic        freq_pending;
  logic        slew_busy;
  logic        upd_done;
  logic        slew_done;

  modport slave (
    input  hc_enable_in, dump_enable,
    input  sw_freq_valid, sw_freq_data,
    input  loop_freq_valid, loop_freq_data,
    input  slew_valid, slew_count,
    output sw_freq_ready, loop_freq_ready, slew_ready,
    output f_control, hc_enable_out, freq_pending, slew_busy,
    output upd_done, slew_done
  );

  modport master (
    output hc_enable_in, dump_enable,
    output sw_freq_valid, sw_freq_data,
    output loop_freq_valid, loop_freq_data,
    output slew_valid, slew_count,
    input  sw_freq_ready, loop_freq_ready, slew_ready,
    input  f_control, hc_enable_out, freq_pending, slew_busy,
    input  upd_done, slew_done
  );
endinterface

// File: rtl/code_nco_ctrl.sv
// Code NCO sequencer: arbitrated frequency-word updates applied on dump
// boundaries, and code-phase slews that swallow half-chip enables.
module code_nco_ctrl #(
  parameter logic [27:0] F_DEFAULT = 28'h1A30552,
  parameter int unsigned MAX_SLEW  = 2046
) (
  input  logic           clk,
  input  logic           rst,
  code_nco_ctrl_if.slave nco
);

  localparam logic [10:0] MAX_SLEW_W = 11'(MAX_SLEW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_SLEW = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic        slew_done_q, slew_done_d;
  logic [27:0] f_control_q, f_control_d;
  logic [27:0] shadow_q, shadow_d;
  logic        pend_q, pend_d;
  logic        upd_done_q, upd_done_d;

  logic        sw_acc, loop_acc, slew_acc;
  logic [10:0] slew_req;

  // Software wins; a colliding loop request sees ready low and simply holds.
  assign sw_acc   = nco.sw_freq_valid && !pend_q;
  assign loop_acc = nco.loop_freq_valid && !pend_q && !nco.sw_freq_valid;

  always_comb begin
    f_control_d = f_control_q;
    shadow_d    = shadow_q;
    pend_d      = pend_q;
    upd_done_d  = 1'b0;
    if (nco.dump_enable && pend_q) begin
      f_control_d = shadow_q;
      pend_d      = 1'b0;
      upd_done_d  = 1'b1;
    end
    // Accepts only happen with pend_q low, so they never race an apply.
    if (sw_acc) begin
      shadow_d = nco.sw_freq_data;
      pend_d   = 1'b1;
    end else if (loop_acc) begin
      shadow_d = nco.loop_freq_data;
      pend_d   = 1'b1;
    end
  end

  assign slew_acc = nco.slew_valid && (state_q == S_IDLE);
  assign slew_req = (nco.slew_count > MAX_SLEW_W) ? MAX_SLEW_W : nco.slew_count;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slew_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (slew_acc) begin
          cnt_d = slew_req;
          if (slew_req == 11'd0) slew_done_d = 1'b1;
          else                   state_d     = S_ARM;
        end
      end
      S_ARM: begin
        if (nco.dump_enable) state_d = S_SLEW;
      end
      S_SLEW: begin
        // cnt_q is never zero here: zero-length requests never leave IDLE.
        if (nco.hc_enable_in) begin
          cnt_d = cnt_q - 11'd1;
          if (cnt_q == 11'd1) begin
            state_d     = S_IDLE;
            slew_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 11'd0;
      slew_done_q <= 1'b0;
      f_control_q <= F_DEFAULT;
      shadow_q    <= 28'd0;
      pend_q      <= 1'b0;
      upd_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slew_done_q <= slew_done_d;
      f_control_q <= f_control_d;
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      upd_done_q  <= upd_done_d;
    end
  end

  assign nco.sw_freq_ready   = !pend_q;
  assign nco.loop_freq_ready = !pend_q && !nco.sw_freq_valid;
  assign nco.slew_ready      = (state_q == S_IDLE);
  assign nco.slew_busy       = (state_q != S_IDLE);
  assign nco.hc_enable_out   = nco.hc_enable_in && (state_q != S_SLEW);
  assign nco.f_control       = f_control_q;
  assign nco.freq_pending    = pend_q;
  assign nco.upd_done        = upd_done_q;
  assign nco.slew_done       = slew_done_q;

endmodule
